router_port_rx: RTL

Packet receiver attached to one output port of the 1x3 router. It drains the port's FIFO through the `vld_out_x`/`rd_en_x` handshake and parses the header, payload and parity bytes. Payload bytes are forwarded on a ready/valid byte stream, and a one-cycle status record is issued per packet. One instance per router port; it is the downstream consumer of `dout_x`.

---
 rtl/router_rx_pkg.sv | 25 ++
 rtl/rx_skid_buf.sv | 51 +++++
 rtl/router_port_rx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_rx_pkg.sv
// Shared types and header field positions for the router port receiver.
package router_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StParity,
    StReport
  } rx_state_e;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
    logic       par_err;
    logic       addr_err;
    logic       timeout;
  } rx_sts_t;

  localparam int unsigned HDR_LEN_MSB  = 7;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_ADDR_LSB = 0;

endpackage

// File: rtl/rx_skid_buf.sv
// Two-entry skid buffer holding {last, data}; push and pop may coincide.
module rx_skid_buf (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [8:0] push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [8:0] data_o,
  output logic [1:0] occ_o
);

  logic [8:0] mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] occ_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

  // Storage, pointers and occupancy; flush drops all entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign data_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/router_port_rx.sv
// Router output port receiver: drains the port FIFO, parses header/payload/parity,
// streams payload bytes and reports one status record per packet.
// Optional packet/error counters are built when ROUTER_RX_STATS_EN is defined.
module router_port_rx
  import router_rx_pkg::*;
#(
  parameter logic [1:0]  PORT_ID     = 2'd0,
  parameter int unsigned TIMEOUT_CYC = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_out,
  input  logic [7:0]  dout,
  output logic        rd_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        sts_valid,
  output logic [5:0]  sts_len,
  output logic [1:0]  sts_addr,
  output logic        sts_par_err,
  output logic        sts_addr_err,
  output logic        sts_timeout,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  rx_state_e  state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] par_q, par_d;
  logic [5:0] rcvd_q, rcvd_d;
  logic [6:0] issued_q, issued_d;
  logic [7:0] tmo_q, tmo_d;
  logic       timeout_q, timeout_d;
  logic       inflight_q;

  logic       rd_en_c;
  logic       push;
  logic       push_last;
  logic       flush;
  logic       pop;
  logic       sts_fire;
  logic [8:0] head;
  logic [1:0] occ;
  logic [2:0] occ_next;
  logic [6:0] len_p1;
  logic       tmo_active;
  logic       idle_cyc;
  logic       tmo_hit;
  rx_sts_t    sts;

  rx_skid_buf u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i ({push_last, dout}),
    .pop_i       (pop),
    .flush_i     (flush),
    .data_o      (head),
    .occ_o       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head[7:0];
  assign m_last  = m_valid && head[8];
  assign pop     = m_valid && m_ready;

  // Occupancy seen by a read issued now: after this cycle's pop, plus the byte landing now.
  assign occ_next   = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight_q};
  assign len_p1     = {1'b0, len_q} + 7'd1;
  assign tmo_active = (state_q == StHdr) || (state_q == StPayload) || (state_q == StParity);
  assign idle_cyc   = !vld_out && !inflight_q;
  assign tmo_hit    = tmo_active && idle_cyc && (tmo_q == TmoLast);

  // Next-state, read issue and byte routing.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    par_d     = par_q;
    rcvd_d    = rcvd_q;
    timeout_d = timeout_q;
    tmo_d     = '0;
    rd_en_c   = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    flush     = 1'b0;
    sts_fire  = 1'b0;

    if (tmo_active && idle_cyc) begin
      tmo_d = tmo_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        rd_en_c = vld_out;
        if (vld_out) begin
          par_d     = '0;
          rcvd_d    = '0;
          timeout_d = 1'b0;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        if (inflight_q) begin
          len_d   = dout[HDR_LEN_MSB:HDR_LEN_LSB];
          addr_d  = dout[HDR_ADDR_MSB:HDR_ADDR_LSB];
          par_d   = dout;
          state_d = (dout[HDR_LEN_MSB:HDR_LEN_LSB] != 6'd0) ? StPayload : StParity;
        end
      end
      StPayload: begin
        // issued_q counts the header read, so len payload reads end at len+1.
        rd_en_c = vld_out && (occ_next < 3'd2) && (issued_q < len_p1);
        if (inflight_q) begin
          push      = 1'b1;
          push_last = (rcvd_q == len_q - 6'd1);
          par_d     = par_q ^ dout;
          rcvd_d    = rcvd_q + 6'd1;
          if (rcvd_q == len_q - 6'd1) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (inflight_q) begin
          par_d   = par_q ^ dout;
          state_d = StReport;
        end else begin
          rd_en_c = vld_out && (issued_q == len_p1);
        end
      end
      StReport: begin
        // Drain the stream first so m_last is always seen before the status.
        if (occ == 2'd0) begin
          sts_fire = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (tmo_hit) begin
      flush     = 1'b1;
      push      = 1'b0;
      rd_en_c   = 1'b0;
      timeout_d = 1'b1;
      tmo_d     = '0;
      state_d   = StReport;
    end

    issued_d = ((state_q == StIdle) ? 7'd0 : issued_q) + {6'd0, rd_en_c};
  end

  // Packet state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      addr_q     <= '0;
      par_q      <= '0;
      rcvd_q     <= '0;
      issued_q   <= '0;
      tmo_q      <= '0;
      timeout_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      par_q      <= par_d;
      rcvd_q     <= rcvd_d;
      issued_q   <= issued_d;
      tmo_q      <= tmo_d;
      timeout_q  <= timeout_d;
      inflight_q <= rd_en_c;
    end
  end

  // Keep the FIFO untouched while reset is held.
  assign rd_en = rd_en_c && !rst;

  assign sts.len      = len_q;
  assign sts.addr     = addr_q;
  assign sts.par_err  = (par_q != 8'd0) && !timeout_q;
  assign sts.addr_err = (addr_q != PORT_ID);
  assign sts.timeout  = timeout_q;

  assign sts_valid    = sts_fire;
  assign sts_len      = sts_fire ? sts.len : 6'd0;
  assign sts_addr     = sts_fire ? sts.addr : 2'd0;
  assign sts_par_err  = sts_fire && sts.par_err;
  assign sts_addr_err = sts_fire && sts.addr_err;
  assign sts_timeout  = sts_fire && sts.timeout;

`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;
  logic        any_err;

  assign any_err = sts.par_err || sts.addr_err || sts.timeout;

  // Saturating packet and error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (sts_fire) begin
      if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (any_err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign pkt_cnt = 16'd0;
  assign err_cnt = 16'd0;
`endif

endmodule
